// File: rtl/start_sync_fifo_srl_pkg.sv
// Shared constants and types for the start-token SRL FIFO.
package start_sync_fifo_srl_pkg;

  typedef struct packed {
    logic empty_n;
    logic full_n;
  } flags_t;

  localparam int CNT_RST = 0;

  localparam flags_t FLAGS_RST = '{
    empty_n: 1'b0,
    full_n:  1'b1
  };

  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/start_sync_fifo_srl_store.sv
// Shift-chain storage with addressed asynchronous read.
// No reset, so synthesis can map it onto SRL primitives.
module start_sync_fifo_srl_store #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        dout = mem[i];
      end
    end
  end

endmodule

// File: rtl/start_sync_fifo_srl.sv
// First-word fall-through SRL FIFO for start tokens.
// Define START_SYNC_FIFO_OCCUPANCY_EN to add occupancy/capacity outputs.
module start_sync_fifo_srl
  import start_sync_fifo_srl_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
`ifdef START_SYNC_FIFO_OCCUPANCY_EN
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap,
`endif
  output logic                  if_empty_n
);

  localparam int CW = cnt_width(ADDR_WIDTH);

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [ADDR_WIDTH-1:0] raddr;
  flags_t                flags;
  logic                  push;
  logic                  pop;

  assign push = if_write_ce & if_write & flags.full_n;
  assign pop  = if_read_ce & if_read & flags.empty_n;

  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      push && !pop: cnt_nxt = cnt + CW'(1);
      pop && !push: cnt_nxt = cnt - CW'(1);
      default:      cnt_nxt = cnt;
    endcase
  end

  // Flags are registered from the next count to keep outputs glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= CW'(CNT_RST);
      flags <= FLAGS_RST;
    end else begin
      cnt           <= cnt_nxt;
      flags.empty_n <= (cnt_nxt != '0);
      flags.full_n  <= (cnt_nxt != CW'(DEPTH));
    end
  end

  // Oldest entry sits at cnt-1; a push shifts it one deeper.
  assign raddr = ADDR_WIDTH'(cnt - CW'(1));

  start_sync_fifo_srl_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk (clk),
    .we  (push),
    .din (if_din),
    .addr(raddr),
    .dout(if_dout)
  );

  assign if_empty_n = flags.empty_n;
  assign if_full_n  = flags.full_n;

`ifdef START_SYNC_FIFO_OCCUPANCY_EN
  assign if_num_data_valid = cnt;
  assign if_fifo_cap       = CW'(DEPTH);
`endif

endmodule

// File: tb/tb_start_sync_fifo_srl.sv
// Scoreboard bench for start_sync_fifo_srl (DEPTH=2, 4-bit data).
module tb_start_sync_fifo_srl;

  localparam int DW = 4;
  localparam int AW = 1;
  localparam int DP = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_write_ce = 1'b0;
  logic          if_write = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n;
  logic          if_read_ce = 1'b0;
  logic          if_read = 1'b0;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
`ifdef START_SYNC_FIFO_OCCUPANCY_EN
  logic [AW:0]   if_num_data_valid;
  logic [AW:0]   if_fifo_cap;
`endif

  int n_tests = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  start_sync_fifo_srl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_write_ce(if_write_ce),
    .if_write   (if_write),
    .if_din     (if_din),
    .if_full_n  (if_full_n),
    .if_read_ce (if_read_ce),
    .if_read    (if_read),
    .if_dout    (if_dout),
`ifdef START_SYNC_FIFO_OCCUPANCY_EN
    .if_num_data_valid(if_num_data_valid),
    .if_fifo_cap      (if_fifo_cap),
`endif
    .if_empty_n (if_empty_n)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop handshake presented mid-cycle pops the scoreboard.
  always @(negedge clk) begin
    if (reset_n && if_read_ce && if_read && if_empty_n) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'(if_dout), 32'hdead);
      end else begin
        check("pop_data", 32'(if_dout), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive one cycle; acc says whether the write must be accepted.
  task automatic step(input string name,
                      input logic w, input logic wce,
                      input logic [DW-1:0] d,
                      input logic r, input logic rce,
                      input logic acc,
                      input logic e_n, input logic f_n,
                      input int ecnt);
    if_write    = w;
    if_write_ce = wce;
    if_din      = d;
    if_read     = r;
    if_read_ce  = rce;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    check({name, "_empty_n"}, 32'(if_empty_n), 32'(e_n));
    check({name, "_full_n"}, 32'(if_full_n), 32'(f_n));
`ifdef START_SYNC_FIFO_OCCUPANCY_EN
    check({name, "_num"}, 32'(if_num_data_valid), 32'(ecnt));
    check({name, "_cap"}, 32'(if_fifo_cap), 32'(DP));
`else
    if (ecnt < 0) $display("bad ecnt");
`endif
  endtask

  task automatic idle();
    if_write    = 1'b0;
    if_write_ce = 1'b0;
    if_read     = 1'b0;
    if_read_ce  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty_n", 32'(if_empty_n), 32'd0);
    check("rst_full_n", 32'(if_full_n), 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // fill / drain
    step("fill1", 1, 1, 4'h1, 0, 0, 1, 1, 1, 1);
    step("fill2", 1, 1, 4'h0, 0, 0, 1, 1, 0, 2);
    step("wr_full", 1, 1, 4'h5, 0, 0, 0, 1, 0, 2);
    step("drain1", 0, 0, 4'h0, 1, 1, 0, 1, 1, 1);
    step("drain2", 0, 0, 4'h0, 1, 1, 0, 0, 1, 0);
    step("rd_empty", 0, 0, 4'h0, 1, 1, 0, 0, 1, 0);

    // clock-enable gating
    step("wce_off", 1, 0, 4'h3, 0, 0, 0, 0, 1, 0);
    step("wce_on", 1, 1, 4'h3, 0, 0, 1, 1, 1, 1);
    step("rce_off", 0, 0, 4'h0, 1, 0, 0, 1, 1, 1);

    // simultaneous push/pop with cnt=1
    step("simul", 1, 1, 4'hb, 1, 1, 1, 1, 1, 1);
    step("simul_pop", 0, 0, 4'h0, 1, 1, 0, 0, 1, 0);

    // boundary collisions
    step("wr_rd_empty", 1, 1, 4'h7, 1, 1, 1, 1, 1, 1);
    step("fill_b", 1, 1, 4'h8, 0, 0, 1, 1, 0, 2);
    step("wr_rd_full", 1, 1, 4'h9, 1, 1, 0, 1, 1, 1);

    // async reset mid-stream with cnt=2
    step("pre_rst", 1, 1, 4'hc, 0, 0, 1, 1, 0, 2);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_empty_n", 32'(if_empty_n), 32'd0);
    check("async_full_n", 32'(if_full_n), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 1, 1, 4'h1, 0, 0, 1, 1, 1, 1);
    check("post_rst_dout", 32'(if_dout), 32'h1);
    step("post_pop", 0, 0, 4'h0, 1, 1, 0, 0, 1, 0);

    idle();
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
